// File: rtl/io_input_port.sv
//==============================================================================
// Module   : io_input_port
// Purpose  : Switch synchronizer/debouncer with sticky change flags and a
//            read-to-clear register window. Optional IO_IRQ_EN adds mask + irq.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module io_input_port #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw0,
    input  logic [WIDTH-1:0] sw1,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] in_port0,
    output logic [WIDTH-1:0] in_port1
`ifdef IO_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [2*WIDTH-1:0] w_raw;
    logic [2*WIDTH-1:0] w_db;
    logic [1:0]         w_set;
    logic [1:0]         flag_d;
    logic [1:0]         flag_q;
    logic [1:0]         w_mask;

    assign w_raw = {sw1, sw0};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [WIDTH-1:0] s1_q;
        logic [WIDTH-1:0] s2_q;
        logic [WIDTH-1:0] db_q;
        logic [CNT_W-1:0] cnt_q;
        logic             w_last;

        assign w_last = (cnt_q == C_CNT_LAST);

        // Count consecutive mismatch cycles; any return to match restarts.
        always_ff @(posedge clock) begin
            if (reset) begin
                s1_q  <= '0;
                s2_q  <= '0;
                db_q  <= '0;
                cnt_q <= '0;
            end else begin
                s1_q <= w_raw[p*WIDTH +: WIDTH];
                s2_q <= s1_q;
                if (s2_q == db_q) begin
                    cnt_q <= '0;
                end else if (w_last) begin
                    db_q  <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign w_db[p*WIDTH +: WIDTH] = db_q;
        assign w_set[p]               = (s2_q != db_q) && w_last;
    end

    assign in_port0 = w_db[WIDTH-1:0];
    assign in_port1 = w_db[2*WIDTH-1:WIDTH];

    // A new acceptance on the same edge as a status read keeps its flag.
    always_comb begin
        flag_d = flag_q;
        if (rd_en && (addr == 2'd2)) begin
            flag_d = 2'b00;
        end
        flag_d = flag_d | w_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flag_q <= 2'b00;
        end else begin
            flag_q <= flag_d;
        end
    end

`ifdef IO_IRQ_EN
    logic [1:0] mask_q;
    logic       irq_q;
    logic       w_unused_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && (addr == 2'd3)) begin
                mask_q <= wdata[1:0];
            end
            irq_q <= |(flag_q & mask_q);
        end
    end

    assign w_mask      = mask_q;
    assign irq         = irq_q;
    assign w_unused_ok = &{1'b0, wdata[31:2]};
`else
    logic w_unused_ok;

    assign w_mask      = 2'b00;
    assign w_unused_ok = &{1'b0, wr_en, wdata};
`endif

    always_comb begin
        rdata = 32'h0;
        case (addr)
            2'd0:    rdata = 32'(in_port0);
            2'd1:    rdata = 32'(in_port1);
            2'd2:    rdata = {30'h0, flag_q};
            default: rdata = {30'h0, w_mask};
        endcase
    end

endmodule

`default_nettype wire

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Input-side peripheral for the pipelined computer's memory-mapped IO.
- Conditions raw board switches into the stable 4-bit values consumed as in_port0/in_port1.
- Each switch group gets a two-flop synchronizer and a per-port debounce counter.
- Sets a sticky change flag per port; the MEM stage reads it through a small read-to-clear register window.

Parameters:
WIDTH, 4, bits per input port (in_port0/in_port1 width)
DB_CYCLES, 16, consecutive mismatch cycles required to accept a new value (min 1)
CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
sw0  input  WIDTH  raw, asynchronous switch group 0
sw1  input  WIDTH  raw, asynchronous switch group 1
rd_en  input  1  MEM-stage read strobe for this device, one cycle per access
wr_en  input  1  MEM-stage write strobe for this device (used only with IO_IRQ_EN)
addr  input  2  word select: 0=port0, 1=port1, 2=status, 3=irq mask
wdata  input  32  write data (used only with IO_IRQ_EN)
rdata  output  32  read data, combinational from addr
in_port0  output  WIDTH  debounced value of sw0
in_port1  output  WIDTH  debounced value of sw1
irq  output  1  interrupt request (present only with IO_IRQ_EN)

Behaviour:
- Reset (clock edge with reset=1): all of the following clear to 0 — sync stages, debounced values, counters, flags, mask. in_port0=in_port1=0, rdata=0 for every addr, irq=0. Reset overrides all other activity, including mid-debounce and a same-edge rd_en.
- Synchronizer: raw -> s1 -> s2, per port. s2 is the only signal compared against the debounced value d.
- Debounce, per port, independent:
  - s2==d: counter <= 0.
  - s2!=d and counter < DB_CYCLES-1: counter <= counter+1.
  - s2!=d and counter == DB_CYCLES-1: d <= s2, counter <= 0, flag <= 1.
- Latency: number the edge that first samples a raw change into s1 as edge 1. If the raw input stays stable, in_port updates on edge DB_CYCLES+2.
- Glitch rejection: a raw pulse shorter than DB_CYCLES cycles after synchronization never changes d or the flag. The counter restarts from 0 on any return to match.
- New target mid-count: if s2 moves to a different non-matching value during a count, the count continues. The value accepted is s2 at the accepting edge.
- Read map, combinational, zero-extended to 32 bits:
  - addr 0: {28'b0, in_port0}
  - addr 1: {28'b0, in_port1}
  - addr 2: {30'b0, flag1, flag0}
  - addr 3: {30'b0, mask} (reads 0 without IO_IRQ_EN)
- Read-to-clear: on an edge with rd_en=1 and addr=2, both flags clear. rdata on that same cycle shows the pre-clear values.
- Simultaneous set and clear on the same edge: set wins, flag stays 1.
- rd_en to addr 0, 1 or 3 has no side effects.
- wr_en is ignored unless IO_IRQ_EN is defined.

Optional Feature:
Macro IO_IRQ_EN.
- Defined:
  - 2-bit mask register, written with wdata[1:0] on an edge with wr_en=1 and addr=3.
  - irq = |(flags & mask), registered: asserts one cycle after the flag sets and deasserts one cycle after the clear.
  - wr_en to addr 0..2 is ignored.
- Undefined:
  - no mask register and no irq port.
  - addr 3 reads 0; wr_en and wdata are unused.

Test Plan:
- Reset: hold reset 2 cycles with sw0=4'hA -> in_port0=0, in_port1=0, status read=0, irq=0.
- Latency (DB_CYCLES=4): sw0 0->4'h5 sampled at edge 1 -> in_port0=4'h5 exactly at edge 6, not before. Status read -> 32'h1.
- Glitch rejection (DB_CYCLES=4): sw1 pulses 4'hF for 3 cycles, then returns to 0 -> in_port1 stays 0, flag1 stays 0.
- Read-to-clear with collision: flag0=1, rd_en at addr=2 on the same edge flag1 sets -> rdata=32'h1 that cycle. Next read -> 32'h2.
- Full read map: sw0=4'h3, sw1=4'hC settled -> addr0 reads 32'h3, addr1 reads 32'hC. rd_en at addr0 leaves flags unchanged.
- IO_IRQ_EN: write mask=2'b10. sw0 change -> irq stays 0. sw1 change -> irq=1 one cycle after flag1 sets. Status read -> irq=0 next cycle.
